operand_bypass: RTL and testbench

//  Stage-6 operand collector; directly consumes registered rs1_read/rs2_read of the stage-5 register file.

---
 rtl/operand_bypass_if.sv | 48 ++++
 rtl/operand_bypass.sv | 143 ++++++++++++++
 tb/tb_operand_bypass.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_bypass_if.sv
// Signal bundle between the stage-6 operand collector and its neighbours:
// upstream issue, the stage-5 regfile, writeback, stage-7 forwarding and downstream.
interface operand_bypass_if #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
);
    logic                 valid_in;
    logic [TAG_W-1:0]     rs1;
    logic [TAG_W-1:0]     rs2;
    logic [TAG_W-1:0]     rd_in;
    logic [PAYLOAD_W-1:0] payload_in;
    logic [XLEN-1:0]      rf_rs1_read;
    logic [XLEN-1:0]      rf_rs2_read;
    logic                 wb_write;
    logic [TAG_W-1:0]     wb_rd;
    logic [XLEN-1:0]      wb_value;
    logic                 fwd_valid;
    logic [TAG_W-1:0]     fwd_rd;
    logic [XLEN-1:0]      fwd_value;
    logic                 fwd_busy;
    logic                 stall_in;
    logic                 flush;
    logic                 valid_out;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [TAG_W-1:0]     rd_out;
    logic [PAYLOAD_W-1:0] payload_out;
    logic                 stall_out;

    modport slave (
        input  valid_in, rs1, rs2, rd_in, payload_in,
        input  rf_rs1_read, rf_rs2_read,
        input  wb_write, wb_rd, wb_value,
        input  fwd_valid, fwd_rd, fwd_value, fwd_busy,
        input  stall_in, flush,
        output valid_out, op1, op2, rd_out, payload_out, stall_out
    );

    modport master (
        output valid_in, rs1, rs2, rd_in, payload_in,
        output rf_rs1_read, rf_rs2_read,
        output wb_write, wb_rd, wb_value,
        output fwd_valid, fwd_rd, fwd_value, fwd_busy,
        output stall_in, flush,
        input  valid_out, op1, op2, rd_out, payload_out, stall_out
    );
endinterface

// File: rtl/operand_bypass.sv
// Stage-6 operand collector: aligns instruction tags with the registered regfile read,
// resolves RAW hazards by bypass and stalls upstream on load-use hazards.
module operand_bypass #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    operand_bypass_if.slave bus
);
    localparam logic [TAG_W-1:0] X0 = '0;

    function automatic logic [XLEN-1:0] select_operand(
        input logic [TAG_W-1:0] tag,
        input logic             hit,
        input logic [XLEN-1:0]  cap,
        input logic [XLEN-1:0]  rf_read,
        input logic             fwd_valid,
        input logic [TAG_W-1:0] fwd_rd,
        input logic [XLEN-1:0]  fwd_value,
        input logic             wb_write,
        input logic [TAG_W-1:0] wb_rd,
        input logic [XLEN-1:0]  wb_value
    );
        if (tag == X0)                         return '0;
        else if (fwd_valid && fwd_rd == tag)   return fwd_value;
        else if (wb_write && wb_rd == tag)     return wb_value;
        else if (hit)                          return cap;
        else                                   return rf_read;
    endfunction

    logic                 a_valid_q, a_valid_d;
    logic [TAG_W-1:0]     a_rs1_q, a_rs1_d;
    logic [TAG_W-1:0]     a_rs2_q, a_rs2_d;
    logic [TAG_W-1:0]     a_rd_q, a_rd_d;
    logic [PAYLOAD_W-1:0] a_payload_q, a_payload_d;
    logic                 hit1_q, hit1_d;
    logic                 hit2_q, hit2_d;
    logic [XLEN-1:0]      cap1_q, cap1_d;
    logic [XLEN-1:0]      cap2_q, cap2_d;
    logic                 valid_out_q, valid_out_d;
    logic [XLEN-1:0]      op1_q, op1_d;
    logic [XLEN-1:0]      op2_q, op2_d;
    logic [TAG_W-1:0]     rd_out_q, rd_out_d;
    logic [PAYLOAD_W-1:0] payload_out_q, payload_out_d;

    logic            hazard;
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;

    always_comb begin
        op1_sel = select_operand(a_rs1_q, hit1_q, cap1_q, bus.rf_rs1_read,
                                 bus.fwd_valid, bus.fwd_rd, bus.fwd_value,
                                 bus.wb_write, bus.wb_rd, bus.wb_value);
        op2_sel = select_operand(a_rs2_q, hit2_q, cap2_q, bus.rf_rs2_read,
                                 bus.fwd_valid, bus.fwd_rd, bus.fwd_value,
                                 bus.wb_write, bus.wb_rd, bus.wb_value);
        hazard  = a_valid_q && bus.fwd_valid && bus.fwd_busy && (bus.fwd_rd != X0) &&
                  ((bus.fwd_rd == a_rs1_q) || (bus.fwd_rd == a_rs2_q));
    end

    // Collision flags track a write landing on the edge the regfile samples the tags,
    // so they are refreshed every edge even while stage A is held.
    always_comb begin
        a_valid_d     = a_valid_q;
        a_rs1_d       = a_rs1_q;
        a_rs2_d       = a_rs2_q;
        a_rd_d        = a_rd_q;
        a_payload_d   = a_payload_q;
        valid_out_d   = valid_out_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        rd_out_d      = rd_out_q;
        payload_out_d = payload_out_q;
        hit1_d        = bus.wb_write && (bus.wb_rd == bus.rs1) && (bus.rs1 != X0);
        hit2_d        = bus.wb_write && (bus.wb_rd == bus.rs2) && (bus.rs2 != X0);
        cap1_d        = bus.wb_value;
        cap2_d        = bus.wb_value;

        if (bus.flush) begin
            a_valid_d   = 1'b0;
            valid_out_d = 1'b0;
        end else if (bus.stall_in) begin
            a_valid_d   = a_valid_q;
        end else if (hazard) begin
            valid_out_d = 1'b0;
        end else begin
            valid_out_d   = a_valid_q;
            op1_d         = op1_sel;
            op2_d         = op2_sel;
            rd_out_d      = a_rd_q;
            payload_out_d = a_payload_q;
            a_valid_d     = bus.valid_in;
            a_rs1_d       = bus.rs1;
            a_rs2_d       = bus.rs2;
            a_rd_d        = bus.rd_in;
            a_payload_d   = bus.payload_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_valid_q     <= 1'b0;
            a_rs1_q       <= '0;
            a_rs2_q       <= '0;
            a_rd_q        <= '0;
            a_payload_q   <= '0;
            hit1_q        <= 1'b0;
            hit2_q        <= 1'b0;
            cap1_q        <= '0;
            cap2_q        <= '0;
            valid_out_q   <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            rd_out_q      <= '0;
            payload_out_q <= '0;
        end else begin
            a_valid_q     <= a_valid_d;
            a_rs1_q       <= a_rs1_d;
            a_rs2_q       <= a_rs2_d;
            a_rd_q        <= a_rd_d;
            a_payload_q   <= a_payload_d;
            hit1_q        <= hit1_d;
            hit2_q        <= hit2_d;
            cap1_q        <= cap1_d;
            cap2_q        <= cap2_d;
            valid_out_q   <= valid_out_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            rd_out_q      <= rd_out_d;
            payload_out_q <= payload_out_d;
        end
    end

    assign bus.valid_out   = valid_out_q;
    assign bus.op1         = op1_q;
    assign bus.op2         = op2_q;
    assign bus.rd_out      = rd_out_q;
    assign bus.payload_out = payload_out_q;
    assign bus.stall_out   = !bus.flush && (bus.stall_in || hazard);

endmodule

// File: tb/tb_operand_bypass.sv
// Bench for operand_bypass: directed hazard scenarios plus a randomized run against
// an architectural reference model (register array + pending writeback + forward).
module tb_operand_bypass;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] regs [32];

    operand_bypass_if bus ();

    operand_bypass dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behaves as the stage-5 register file: registered reads, writes visible next edge.
    always @(posedge clock) begin
        bus.rf_rs1_read <= regs[bus.rs1];
        bus.rf_rs2_read <= regs[bus.rs2];
        if (bus.wb_write && bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_value;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs;
        bus.valid_in   = 1'b0;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.rd_in      = '0;
        bus.payload_in = '0;
        bus.wb_write   = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_value   = '0;
        bus.fwd_valid  = 1'b0;
        bus.fwd_rd     = '0;
        bus.fwd_value  = '0;
        bus.fwd_busy   = 1'b0;
        bus.stall_in   = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Architecturally current value of a register as seen by the instruction leaving stage A.
    function automatic logic [31:0] ref_operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.fwd_valid && bus.fwd_rd == r) return bus.fwd_value;
        if (bus.wb_write && bus.wb_rd == r) return bus.wb_value;
        return regs[r];
    endfunction

    task automatic preload_regs;
        for (int r = 1; r < 32; r++) begin
            idle_inputs();
            bus.wb_write = 1'b1;
            bus.wb_rd    = 5'(r);
            case (r)
                3, 7:    bus.wb_value = 32'h1;
                5:       bus.wb_value = 32'h11;
                9:       bus.wb_value = 32'h5;
                default: bus.wb_value = $urandom;
            endcase
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd5;
        bus.rd_in    = 5'd1;
        bus.payload_in = 64'hCAFE;
        repeat (3) next_cycle();
        checks++;
        if (bus.valid_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_prestream_valid: got %b expected 1", bus.valid_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.op1 !== 32'd0 || bus.op2 !== 32'd0 ||
            bus.rd_out !== 5'd0 || bus.payload_out !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%b op1=%h op2=%h rd=%h pl=%h expected all zero",
                     bus.valid_out, bus.op1, bus.op2, bus.rd_out, bus.payload_out);
        end
        checks++;
        if (bus.stall_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall_out);
        end
        next_cycle();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_holds_over_valid_in: got %b expected 0", bus.valid_out);
        end
        reset_n = 1'b1;
        idle_inputs();
        repeat (2) next_cycle();
    endtask

    task automatic test_plain;
        idle_inputs();
        bus.valid_in   = 1'b1;
        bus.rs1        = 5'd5;
        bus.rs2        = 5'd0;
        bus.rd_in      = 5'd4;
        bus.payload_in = 64'h1234_5678_9ABC_DEF0;
        next_cycle();
        idle_inputs();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL plain_latency: got valid_out=%b after 1 edge expected 0", bus.valid_out);
        end
        next_cycle();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.op1 !== 32'h11 || bus.op2 !== 32'h0 ||
            bus.rd_out !== 5'd4 || bus.payload_out !== 64'h1234_5678_9ABC_DEF0) begin
            errors++;
            $display("[TB] FAIL plain_result: got v=%b op1=%h op2=%h rd=%h pl=%h expected v=1 op1=11 op2=0 rd=4 pl=123456789abcdef0",
                     bus.valid_out, bus.op1, bus.op2, bus.rd_out, bus.payload_out);
        end
        next_cycle();
    endtask

    task automatic test_collision;
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd7;
        bus.rd_in    = 5'd2;
        bus.wb_write = 1'b1;
        bus.wb_rd    = 5'd7;
        bus.wb_value = 32'hABCD;
        next_cycle();
        idle_inputs();
        next_cycle();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.op1 !== 32'hABCD) begin
            errors++;
            $display("[TB] FAIL collision_op1: got v=%b op1=%h expected v=1 op1=0000abcd", bus.valid_out, bus.op1);
        end
        next_cycle();
    endtask

    task automatic test_priority;
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd3;
        bus.rd_in    = 5'd6;
        next_cycle();
        idle_inputs();
        bus.fwd_valid = 1'b1;
        bus.fwd_rd    = 5'd3;
        bus.fwd_value = 32'h33;
        bus.wb_write  = 1'b1;
        bus.wb_rd     = 5'd3;
        bus.wb_value  = 32'h22;
        next_cycle();
        idle_inputs();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.op1 !== 32'h33) begin
            errors++;
            $display("[TB] FAIL priority_fwd_over_wb: got v=%b op1=%h expected v=1 op1=33", bus.valid_out, bus.op1);
        end
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd0;
        bus.rs2      = 5'd3;
        next_cycle();
        idle_inputs();
        bus.fwd_valid = 1'b1;
        bus.fwd_rd    = 5'd0;
        bus.fwd_value = 32'h55;
        bus.wb_write  = 1'b1;
        bus.wb_rd     = 5'd0;
        bus.wb_value  = 32'h66;
        next_cycle();
        idle_inputs();
        checks++;
        if (bus.op1 !== 32'h0 || bus.op2 !== 32'h22) begin
            errors++;
            $display("[TB] FAIL priority_x0: got op1=%h op2=%h expected op1=0 op2=22", bus.op1, bus.op2);
        end
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd3;
        bus.rs2      = 5'd0;
        next_cycle();
        idle_inputs();
        bus.wb_write = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_value = 32'h44;
        next_cycle();
        idle_inputs();
        checks++;
        if (bus.op1 !== 32'h44) begin
            errors++;
            $display("[TB] FAIL priority_wb_over_rf: got op1=%h expected 44", bus.op1);
        end
        next_cycle();
    endtask

    task automatic test_load_use;
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd0;
        bus.rs2      = 5'd9;
        bus.rd_in    = 5'd1;
        next_cycle();
        bus.valid_in  = 1'b0;
        bus.fwd_valid = 1'b1;
        bus.fwd_rd    = 5'd9;
        bus.fwd_busy  = 1'b1;
        bus.fwd_value = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.stall_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load_use_stall_%0d: got %b expected 1", i, bus.stall_out);
            end
            next_cycle();
            checks++;
            if (bus.valid_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_use_bubble_%0d: got valid_out=%b expected 0", i, bus.valid_out);
            end
        end
        bus.fwd_busy  = 1'b0;
        bus.fwd_value = 32'h99;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_use_release: got stall_out=%b expected 0", bus.stall_out);
        end
        next_cycle();
        idle_inputs();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.op2 !== 32'h99 || bus.op1 !== 32'h0 || bus.rd_out !== 5'd1) begin
            errors++;
            $display("[TB] FAIL load_use_result: got v=%b op1=%h op2=%h rd=%h expected v=1 op1=0 op2=99 rd=1",
                     bus.valid_out, bus.op1, bus.op2, bus.rd_out);
        end
        next_cycle();
    endtask

    task automatic test_flush_vs_stall;
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd3;
        next_cycle();
        bus.rs1      = 5'd5;
        next_cycle();
        bus.flush    = 1'b1;
        bus.stall_in = 1'b1;
        bus.rs1      = 5'd3;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stall_out: got %b expected 0", bus.stall_out);
        end
        next_cycle();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_kills_output: got valid_out=%b expected 0", bus.valid_out);
        end
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.rs1      = 5'd5;
        bus.rd_in    = 5'd8;
        next_cycle();
        idle_inputs();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_kills_stage_a: got valid_out=%b expected 0", bus.valid_out);
        end
        next_cycle();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.op1 !== 32'h11 || bus.rd_out !== 5'd8) begin
            errors++;
            $display("[TB] FAIL flush_new_accepted: got v=%b op1=%h rd=%h expected v=1 op1=11 rd=8",
                     bus.valid_out, bus.op1, bus.rd_out);
        end
        next_cycle();
    endtask

    // Stalls and load-use are only raised while the presented tags match the
    // instruction waiting in stage A, so the regfile re-read stays meaningful.
    task automatic test_random(input int n);
        logic        m_a_v, m_v, hz, exp_stall, hold, tags_match;
        logic [4:0]  m_a_rs1, m_a_rs2, m_a_rd, m_rd;
        logic [63:0] m_a_pay, m_pay;
        logic [31:0] m_op1, m_op2;
        idle_inputs();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        m_a_v = 0; m_v = 0; hold = 0;
        m_a_rs1 = 0; m_a_rs2 = 0; m_a_rd = 0; m_a_pay = 0;
        m_rd = 0; m_pay = 0; m_op1 = 0; m_op2 = 0;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (bus.valid_out !== m_v) begin
                errors++;
                $display("[TB] FAIL rand_valid cycle %0d: got %b expected %b", c, bus.valid_out, m_v);
            end
            if (m_v) begin
                checks++;
                if (bus.op1 !== m_op1 || bus.op2 !== m_op2 || bus.rd_out !== m_rd || bus.payload_out !== m_pay) begin
                    errors++;
                    $display("[TB] FAIL rand_data cycle %0d: got op1=%h op2=%h rd=%h pl=%h expected op1=%h op2=%h rd=%h pl=%h",
                             c, bus.op1, bus.op2, bus.rd_out, bus.payload_out, m_op1, m_op2, m_rd, m_pay);
                end
            end
            if (!hold) begin
                bus.valid_in = ($urandom_range(0, 3) != 0);
                if (m_a_v && $urandom_range(0, 2) == 0) begin
                    bus.rs1 = m_a_rs1;
                    bus.rs2 = m_a_rs2;
                end else begin
                    bus.rs1 = 5'($urandom_range(0, 7));
                    bus.rs2 = 5'($urandom_range(0, 7));
                end
                bus.rd_in      = 5'($urandom_range(0, 31));
                bus.payload_in = {$urandom, $urandom};
            end
            tags_match    = !m_a_v || (bus.rs1 == m_a_rs1 && bus.rs2 == m_a_rs2);
            bus.wb_write  = $urandom_range(0, 1) == 1;
            bus.wb_rd     = 5'($urandom_range(0, 7));
            bus.wb_value  = $urandom;
            bus.fwd_valid = $urandom_range(0, 1) == 1;
            bus.fwd_rd    = 5'($urandom_range(0, 7));
            bus.fwd_value = $urandom;
            bus.fwd_busy  = tags_match && ($urandom_range(0, 2) == 0);
            bus.stall_in  = tags_match && ($urandom_range(0, 5) == 0);
            bus.flush     = ($urandom_range(0, 24) == 0);
            #1;
            hz = m_a_v && bus.fwd_valid && bus.fwd_busy && bus.fwd_rd != 5'd0 &&
                 (bus.fwd_rd == m_a_rs1 || bus.fwd_rd == m_a_rs2);
            exp_stall = !bus.flush && (bus.stall_in || hz);
            checks++;
            if (bus.stall_out !== exp_stall) begin
                errors++;
                $display("[TB] FAIL rand_stall cycle %0d: got %b expected %b", c, bus.stall_out, exp_stall);
            end
            if (bus.flush) begin
                m_a_v = 0;
                m_v   = 0;
            end else if (bus.stall_in) begin
                m_v = m_v;
            end else if (hz) begin
                m_v = 0;
            end else begin
                m_v     = m_a_v;
                m_op1   = ref_operand(m_a_rs1);
                m_op2   = ref_operand(m_a_rs2);
                m_rd    = m_a_rd;
                m_pay   = m_a_pay;
                m_a_v   = bus.valid_in;
                m_a_rs1 = bus.rs1;
                m_a_rs2 = bus.rs2;
                m_a_rd  = bus.rd_in;
                m_a_pay = bus.payload_in;
            end
            hold = exp_stall;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        $display("[TB] preloading register file");
        preload_regs();
        test_reset();
        test_plain();
        test_collision();
        test_priority();
        test_load_use();
        test_flush_vs_stall();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
